// File: rtl/fnd_scan_controller.sv
// Multi-digit common-anode 7-segment scan controller with a sequential double-dabble BCD converter.
// Optional feature: define FND_LZ_BLANK_EN to blank leading zeros (ones digit always shown).
module fnd_scan_controller #(
  parameter int DATA_W  = 14,
  parameter int DIGITS  = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              load,
  input  logic [DIGITS-1:0] dp_mask,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] fnd_com,
  output logic [7:0]        fnd_data
);

  // Nibbles needed for the full conversion of 2^DATA_W-1, plus one, and never fewer than DIGITS.
  function automatic int calc_nib(input int w, input int d);
    longint unsigned maxv;
    int n;
    maxv = (64'd1 << w) - 64'd1;
    n = 0;
    while (maxv != 0) begin
      n++;
      maxv = maxv / 10;
    end
    n = n + 1;
    if (n < d) n = d;
    return n;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return 8'hc0;
      4'd1:    return 8'hf9;
      4'd2:    return 8'ha4;
      4'd3:    return 8'hb0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hf8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hff;
    endcase
  endfunction

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int PRE_W    = $clog2(SCAN_DIV);
  localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W    = $clog2(DATA_W + 1);
  localparam int NIB      = calc_nib(DATA_W, DIGITS);
  localparam int BCD_W    = NIB * 4;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                   state, state_nx;
  logic [DATA_W-1:0]        shreg;
  logic [BCD_W-1:0]         bcd;
  logic [BCD_W-1:0]         bcd_adj;
  logic [CNT_W-1:0]         bit_cnt;
  logic [DIGITS-1:0]        dp_lat;
  logic                     upper_nz;

  logic [DIGITS-1:0][3:0]   disp;
  logic [DIGITS-1:0]        disp_dp;
  logic [PRE_W-1:0]         presc;
  logic [IDX_W-1:0]         idx;
  logic [7:0]               seg;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (load) state_nx = SHIFT;
      SHIFT:   if (bit_cnt == CNT_W'(1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NIB; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Any nonzero nibble above the displayed ones means the value exceeds 10^DIGITS-1.
  always_comb begin
    upper_nz = 1'b0;
    for (int i = DIGITS; i < NIB; i++) begin
      upper_nz = upper_nz | (|bcd[i*4 +: 4]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bcd     <= '0;
      bit_cnt <= '0;
      dp_lat  <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          shreg   <= data;
          dp_lat  <= dp_mask;
          bcd     <= '0;
          bit_cnt <= CNT_W'(DATA_W);
        end
        SHIFT: begin
          {bcd, shreg} <= {bcd_adj, shreg} << 1;
          bit_cnt      <= bit_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Display register only changes on COMMIT, so partial conversions are never visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp    <= '0;
      disp_dp <= '0;
      ovf     <= 1'b0;
    end else if (state == COMMIT) begin
      disp    <= bcd[DIGITS*4-1:0];
      disp_dp <= dp_lat;
      ovf     <= upper_nz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

`ifdef FND_LZ_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              seen_nz;

  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      blank[i] = !seen_nz && (disp[i] == 4'd0);
      seen_nz  = seen_nz || (disp[i] != 4'd0);
    end
  end
`endif

  always_comb begin
    seg = ovf ? 8'hbf : seg_decode(disp[idx]);
`ifdef FND_LZ_BLANK_EN
    if (!ovf && (idx != '0) && blank[idx]) seg = 8'hff;
`endif
    if (disp_dp[idx]) seg[7] = 1'b0;
  end

  assign fnd_data = seg;
  assign fnd_com  = ~(DIGITS'(1) << idx);

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: stimulus pushes expected values, a monitor
// checks busy length, ovf and one full scan frame after every commit.
module tb_fnd_scan_controller;

  localparam int DATA_W   = 14;
  localparam int DIGITS   = 4;
  localparam int CLK_HZ   = 40;
  localparam int SCAN_HZ  = 10;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  typedef struct {
    int unsigned val;
    logic [3:0]  dp;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [DATA_W-1:0] data;
  logic              load;
  logic [DIGITS-1:0] dp_mask;
  logic              busy;
  logic              ovf;
  logic [DIGITS-1:0] fnd_com;
  logic [7:0]        fnd_data;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  bit   checking = 0;

  fnd_scan_controller #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS),
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .data    (data),
    .load    (load),
    .dp_mask (dp_mask),
    .busy    (busy),
    .ovf     (ovf),
    .fnd_com (fnd_com),
    .fnd_data(fnd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input int unsigned d);
    case (d)
      0: return 8'hc0;  1: return 8'hf9;  2: return 8'ha4;  3: return 8'hb0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hf8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hff;
    endcase
  endfunction

  // Reference: decimal digit i of v by plain arithmetic.
  function automatic logic [7:0] exp_seg(input int unsigned v, input logic [3:0] dp, input int i);
    int unsigned p;
    logic [7:0]  s;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (v > 9999) s = 8'hbf;
    else          s = glyph((v / p) % 10);
`ifdef FND_LZ_BLANK_EN
    if (v <= 9999 && i > 0 && v < p) s = 8'hff;
`endif
    if (dp[i]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic frame_check(input int unsigned v, input logic [3:0] dp);
    int cnt[DIGITS];
    int zeros;
    int sel;
    for (int i = 0; i < DIGITS; i++) cnt[i] = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      zeros = 0;
      sel   = 0;
      for (int i = 0; i < DIGITS; i++) begin
        if (!fnd_com[i]) begin
          zeros++;
          sel = i;
        end
      end
      check("com_one_hot_zero", zeros, 1);
      if (zeros == 1) begin
        cnt[sel]++;
        check($sformatf("seg_val%0d_dig%0d", v, sel), fnd_data, exp_seg(v, dp, sel));
      end
    end
    for (int i = 0; i < DIGITS; i++) check($sformatf("dwell_dig%0d", i), cnt[i], SCAN_DIV);
  endtask

  // Monitor: each falling edge of busy is a commit; pop and compare.
  initial begin
    bit   prev_busy;
    int   busy_len;
    exp_t e;
    prev_busy = 0;
    busy_len  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 0;
        busy_len  = 0;
      end else begin
        if (busy) busy_len++;
        if (prev_busy && !busy) begin
          checking = 1;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_commit: busy fell with empty scoreboard at %0t", $time);
          end else begin
            e = sb.pop_front();
            check($sformatf("busy_len_val%0d", e.val), busy_len, DATA_W + 1);
            check($sformatf("ovf_val%0d", e.val), ovf, (e.val > 9999) ? 1 : 0);
            frame_check(e.val, e.dp);
          end
          busy_len = 0;
          checking = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic do_load(input int unsigned v, input logic [3:0] dp, input bit accept);
    exp_t e;
    @(negedge clk);
    data    = DATA_W'(v);
    dp_mask = dp;
    load    = 1'b1;
    if (accept) begin
      e.val = v;
      e.dp  = dp;
      sb.push_back(e);
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || checking) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: scoreboard depth %0d after %0d cycles", sb.size(), n);
      sb.delete();
    end
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    load    = 1'b0;
    data    = '0;
    dp_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_com", fnd_com, 4'b1110);
    check("rst_data", fnd_data, 8'hc0);
    reset = 1'b0;
    @(negedge clk);
    frame_check(0, 4'b0000);

    do_load(1234, 4'b0000, 1); wait_idle();
    do_load(9999, 4'b0000, 1); wait_idle();
    do_load(10000, 4'b0000, 1); wait_idle();

    do_load(7, 4'b0000, 1);
    repeat (3) @(negedge clk);
    check("busy_mid_conv", busy, 1);
    do_load(42, 4'b0000, 0);
    wait_idle();

    do_load(5, 4'b0010, 1); wait_idle();

    do_load(8191, 4'b0000, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    void'(sb.pop_back());
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_com", fnd_com, 4'b1110);
    check("midrst_data", fnd_data, 8'hc0);
    @(negedge clk);
    #1 reset = 1'b0;
    do_load(8191, 4'b0000, 1); wait_idle();

    do_load(16383, 4'b1001, 1); wait_idle();
    do_load(0, 4'b0001, 1); wait_idle();

    for (int r = 0; r < 12; r++) begin
      do_load($urandom_range(0, 16383), 4'($urandom_range(0, 15)), 1);
      wait_idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
